fixed_divider: RTL and testbench
================================

Name: fixed_divider

Overview:
Sequential signed fixed-point divider, the inverse operator of the team's Q-format multiplier in the FFT datapath. It takes the dividend A and divisor B in signed two's-complement QN.Q format and returns C = A / B in the same format. Used for normalisation and scaling after the FFT stages. It uses sign-magnitude restoring division, one quotient bit per clock, with a start/busy/done handshake.

Parameters:
N, 16, total word width in bits (signed two's complement)
Q, 8, number of fractional bits; must satisfy 0 <= Q < N

Ports:
clk  input  1  clock; all registers update on the rising edge
rst  input  1  asynchronous, active-low reset (low = reset asserted)
start  input  1  request; sampled only in IDLE
A  input  N  dividend, QN.Q signed; captured on the accepted start
B  input  N  divisor, QN.Q signed; captured on the accepted start
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse; C and the flags are valid from this cycle
C  output  N  quotient, QN.Q signed; held until the next done
ovf  output  1  the quotient saturated; valid with done, held
dz  output  1  divide by zero; valid with done, held

Behaviour:
- Reset (rst low, any time, including mid-division): state=IDLE; busy, done, C, ovf and dz all 0; the internal counter and remainder are cleared. start is ignored while rst is low.
- States are IDLE, CALC and FIX.
- IDLE: on start=1:
  - Latch sA=A[N-1] and sB=B[N-1], plus the N-bit unsigned magnitudes |A| and |B|. -2^(N-1) maps to magnitude 2^(N-1).
  - Set the dividend shift register to |A|<<Q (N+Q bits), clear the remainder, and set cnt=0.
  - If B==0, go to FIX with the dz path; otherwise go to CALC.
- CALC: one restoring step per cycle, MSB first:
  - rem = {rem, next dividend bit}.
  - If rem >= |B|: rem -= |B| and the quotient bit is 1; otherwise the quotient bit is 0.
  - After N+Q steps (cnt == N+Q-1), go to FIX.
- FIX (1 cycle): magnitude M is N+Q bits. Negative result when sA^sB.
  - Positive result: if M > 2^(N-1)-1, then C=2^(N-1)-1 and ovf=1. Otherwise C=M[N-1:0].
  - Negative result: if M > 2^(N-1), then C=-2^(N-1) and ovf=1. Otherwise C = -M (two's complement, N bits).
  - dz path: dz=1, ovf=0. C=2^(N-1)-1 when sA=0, or -2^(N-1) when sA=1. A=0, B=0 gives the positive maximum.
  - done=1 for this one transition, then return to IDLE.
- Latency from the start-accept edge to done:
  - normal division: N+Q+1 edges (25 with defaults);
  - divide by zero: 1 edge.
- Rounding: truncation toward zero (on the magnitude).
- start while busy=1 is ignored; there is no queueing.
- start high in the same cycle done is high is accepted, giving back-to-back operation.
- busy=0 in IDLE. done is never high while busy is high.
- ovf and dz are both cleared on every accepted start.

Optional Feature:
Macro FIXED_DIV_ROUND_EN.
- Defined: CALC runs N+Q+1 steps to produce one guard bit. FIX adds the guard bit to the magnitude (round half away from zero), then applies sign and saturation. Normal latency becomes N+Q+2; the dz latency is unchanged.
- Undefined: truncation toward zero with N+Q steps, as above.

Decomposition:
- Package fixed_pkg holds:
  - the state enum (IDLE, CALC, FIX);
  - a function for the max-positive/min-negative saturation constants in terms of N;
  - the counter width localparam, $clog2(N+Q+1).
- Sub-module fixed_sign_mag is combinational. It maps an N-bit signed input to a sign bit plus an N-bit unsigned magnitude, and the inverse; it is instantiated for the operands and the result.
- The restoring-step datapath stays inline.

Test Plan:
- A=0x0300 (3.0), B=0x0200 (2.0), start pulse -> busy high, done exactly 25 cycles later, C=0x0180, ovf=0, dz=0.
- A=0xFD00 (-3.0), B=0x0200; then A=0xFD00, B=0xFE00 -> C=0xFE80, then C=0x0180 (signs handled, back-to-back start accepted on the done cycle).
- A=0x0200, B=0x0300 -> C=0x00AA without the macro; C=0x00AB and 26-cycle latency with FIXED_DIV_ROUND_EN.
- A=0x7F00, B=0x0080 -> C=0x7FFF, ovf=1. A=0x8000, B=0x0080 -> C=0x8000, ovf=1.
- A=0xFD00, B=0x0000 -> done 1 cycle after start, C=0x8000, dz=1. A=0x0000, B=0x0000 -> C=0x7FFF, dz=1.
- Pulse start, then rst low at cycle 10 -> all outputs 0 immediately. After release with no start: no done, busy=0. A start pulse during busy is ignored and the in-flight result is unchanged.

Source files
------------

// File: rtl/fixed_pkg.sv
// -----------------------------------------------------------------------------
// fixed_pkg
// Shared definitions for the signed QN.Q sequential divider:
//   - fixed_state_e : controller states (IDLE, CALC, FIX)
//   - FIXED_CNT_W   : step-counter width for the default N=16, Q=8 build
//   - fixed_cnt_w() : step-counter width for any N, Q
//   - fixed_sat()   : saturation bit patterns (max positive / min negative)
// -----------------------------------------------------------------------------
package fixed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } fixed_state_e;

    localparam int unsigned FIXED_N_DEF = 16;
    localparam int unsigned FIXED_Q_DEF = 8;
    localparam int unsigned FIXED_CNT_W = $clog2(FIXED_N_DEF + FIXED_Q_DEF + 1);

    // Counter must hold N+Q, the last step index when the guard bit is enabled.
    function automatic int unsigned fixed_cnt_w(input int unsigned n, input int unsigned q);
        return $clog2(n + q + 1);
    endfunction

    // Bit pattern of the saturation value for an n-bit two's-complement word:
    // neg=0 gives 2^(n-1)-1, neg=1 gives -2^(n-1) (which is 2^(n-1) as a pattern).
    function automatic logic [63:0] fixed_sat(input int unsigned n, input logic neg);
        logic [63:0] v;
        if (neg) begin
            v = 64'd1 << (n - 1);
        end else begin
            v = (64'd1 << (n - 1)) - 64'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fixed_sign_mag.sv
// -----------------------------------------------------------------------------
// fixed_sign_mag
// Combinational conditional two's-complement negation, used in both directions:
//   signed -> magnitude : neg_i = val_i[N-1]; res_o = |val_i| (N-bit unsigned,
//                         so -2^(N-1) maps to 2^(N-1))
//   magnitude -> signed : neg_i = result sign; res_o = signed N-bit result
// Ports:
//   val_i [N-1:0] input value
//   neg_i         negate when 1
//   res_o [N-1:0] result
// -----------------------------------------------------------------------------
module fixed_sign_mag #(
    parameter int N = 16
) (
    input  logic [N-1:0] val_i,
    input  logic         neg_i,
    output logic [N-1:0] res_o
);

    // Negate or pass through.
    always_comb begin
        res_o = val_i;
        if (neg_i) begin
            res_o = ~val_i + {{(N-1){1'b0}}, 1'b1};
        end else begin
            res_o = val_i;
        end
    end

endmodule

// File: rtl/fixed_divider.sv
// -----------------------------------------------------------------------------
// fixed_divider
// Sequential signed QN.Q divider, C = A / B, using sign-magnitude restoring
// division (one quotient bit per clock) with a start/busy/done handshake.
// Optional build macro FIXED_DIV_ROUND_EN: computes one extra guard bit and
// rounds half away from zero; otherwise the result truncates toward zero.
// Ports:
//   clk   clock (rising edge)
//   rst   asynchronous active-low reset
//   start request, sampled only in IDLE
//   A, B  dividend / divisor, QN.Q signed, captured on accepted start
//   busy  high from the cycle after acceptance until done
//   done  one-cycle pulse, C/ovf/dz valid from this cycle
//   C     quotient, held until the next done
//   ovf   quotient saturated
//   dz    divide by zero
// -----------------------------------------------------------------------------
module fixed_divider
    import fixed_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] C,
    output logic         ovf,
    output logic         dz
);

`ifdef FIXED_DIV_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif
    localparam int STEPS = N + Q + GUARD;   // quotient bits produced
    localparam int MW    = N + Q + 1;       // final magnitude width (room for the round carry)
    localparam int CW    = int'(fixed_cnt_w(N, Q));

    localparam logic [N-1:0]  SAT_POS = N'(fixed_sat(N, 1'b0));
    localparam logic [N-1:0]  SAT_NEG = N'(fixed_sat(N, 1'b1));
    localparam logic [MW-1:0] LIM_POS = MW'(fixed_sat(N, 1'b0));
    localparam logic [MW-1:0] LIM_NEG = MW'(fixed_sat(N, 1'b1));

    fixed_state_e      state_q;
    logic              sa_q;
    logic              sb_q;
    logic              dzp_q;       // current operation is a divide by zero
    logic [N-1:0]      magb_q;
    logic [STEPS-1:0]  dvd_q;       // dividend bits still to be shifted in, MSB first
    logic [N-1:0]      rem_q;
    logic [STEPS-1:0]  quo_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [N-1:0]      c_q;
    logic              ovf_q;
    logic              dz_q;

    logic [N-1:0]      mag_a_s;
    logic [N-1:0]      mag_b_s;
    logic [STEPS-1:0]  dvd_init_s;
    logic [N:0]        rem_shift_s;
    logic              ge_s;
    logic [N-1:0]      rem_d;
    logic [STEPS-1:0]  quo_d;
    logic [STEPS-1:0]  dvd_d;
    logic [MW-1:0]     mag_fix_s;
    logic              neg_s;
    logic [N-1:0]      res_val_s;
    logic [N-1:0]      fix_c_s;
    logic              fix_ovf_s;

    fixed_sign_mag #(.N(N)) u_mag_a (
        .val_i (A),
        .neg_i (A[N-1]),
        .res_o (mag_a_s)
    );

    fixed_sign_mag #(.N(N)) u_mag_b (
        .val_i (B),
        .neg_i (B[N-1]),
        .res_o (mag_b_s)
    );

    // Fraction scaling: |A| << Q (plus one more place for the guard bit).
    assign dvd_init_s = STEPS'(mag_a_s) << (Q + GUARD);

    // One restoring step. The shifted remainder is N+1 bits; when its top bit is
    // set it certainly exceeds |B|, and the true difference always fits N bits,
    // so an N-bit modular subtraction is exact.
    always_comb begin
        rem_shift_s = {rem_q, dvd_q[STEPS-1]};
        ge_s        = rem_shift_s[N] | (rem_shift_s[N-1:0] >= magb_q);
        if (ge_s) begin
            rem_d = rem_shift_s[N-1:0] - magb_q;
        end else begin
            rem_d = rem_shift_s[N-1:0];
        end
        quo_d = {quo_q[STEPS-2:0], ge_s};
        dvd_d = {dvd_q[STEPS-2:0], 1'b0};
    end

`ifdef FIXED_DIV_ROUND_EN
    assign mag_fix_s = {1'b0, quo_q[STEPS-1:1]} + MW'(quo_q[0]);
`else
    assign mag_fix_s = {1'b0, quo_q};
`endif

    assign neg_s = sa_q ^ sb_q;

    fixed_sign_mag #(.N(N)) u_res (
        .val_i (mag_fix_s[N-1:0]),
        .neg_i (neg_s),
        .res_o (res_val_s)
    );

    // Result selection in FIX: divide-by-zero, saturation, or signed magnitude.
    always_comb begin
        fix_c_s   = res_val_s;
        fix_ovf_s = 1'b0;
        if (dzp_q) begin
            fix_c_s   = sa_q ? SAT_NEG : SAT_POS;
            fix_ovf_s = 1'b0;
        end else if (neg_s) begin
            if (mag_fix_s > LIM_NEG) begin
                fix_c_s   = SAT_NEG;
                fix_ovf_s = 1'b1;
            end else begin
                fix_c_s   = res_val_s;
                fix_ovf_s = 1'b0;
            end
        end else begin
            if (mag_fix_s > LIM_POS) begin
                fix_c_s   = SAT_POS;
                fix_ovf_s = 1'b1;
            end else begin
                fix_c_s   = mag_fix_s[N-1:0];
                fix_ovf_s = 1'b0;
            end
        end
    end

    // Controller and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dzp_q   <= 1'b0;
            magb_q  <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= A[N-1];
                        sb_q    <= B[N-1];
                        dzp_q   <= (B == '0);
                        magb_q  <= mag_b_s;
                        dvd_q   <= dvd_init_s;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                        dz_q    <= 1'b0;
                        state_q <= (B == '0) ? FIX : CALC;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(STEPS - 1)) begin
                        state_q <= FIX;
                    end else begin
                        state_q <= CALC;
                    end
                end
                FIX: begin
                    c_q     <= fix_c_s;
                    ovf_q   <= fix_ovf_s;
                    dz_q    <= dzp_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign C    = c_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_fixed_divider.sv
// -----------------------------------------------------------------------------
// tb_fixed_divider
// Self-checking bench for fixed_divider (N=16, Q=8): directed cases, reset and
// ignored-start behaviour, then randomized operands against an arithmetic model.
// Build with FIXED_DIV_ROUND_EN defined to check the rounding variant.
// -----------------------------------------------------------------------------
module tb_fixed_divider;

    localparam int N = 16;
    localparam int Q = 8;
`ifdef FIXED_DIV_ROUND_EN
    localparam int LAT = N + Q + 2;
    localparam logic [15:0] TWO_THIRDS = 16'h00AB;
`else
    localparam int LAT = N + Q + 1;
    localparam logic [15:0] TWO_THIRDS = 16'h00AA;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  A     = '0;
    logic [N-1:0]  B     = '0;
    logic          busy;
    logic          done;
    logic [N-1:0]  C;
    logic          ovf;
    logic          dz;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    fixed_divider #(.N(N), .Q(Q)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .C     (C),
        .ovf   (ovf),
        .dz    (dz)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {dz, ovf, C} from plain integer arithmetic.
    function automatic logic [17:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        longint av, bv, ma, mb, num, m, pmax;
        logic   neg;
        logic   ov;
        logic [15:0] c;
        av   = longint'($signed(a));
        bv   = longint'($signed(b));
        ma   = (av < 0) ? -av : av;
        mb   = (bv < 0) ? -bv : bv;
        pmax = longint'(1) << (N - 1);
        if (mb == 0) begin
            return {1'b1, 1'b0, (a[15] ? 16'h8000 : 16'h7FFF)};
        end
        num = ma << Q;
`ifdef FIXED_DIV_ROUND_EN
        m = ((2 * num) / mb + 1) / 2;
`else
        m = num / mb;
`endif
        neg = a[15] ^ b[15];
        ov  = 1'b0;
        if (neg) begin
            if (m > pmax) begin c = 16'h8000; ov = 1'b1; end
            else          begin c = 16'(-m); end
        end else begin
            if (m > pmax - 1) begin c = 16'h7FFF; ov = 1'b1; end
            else              begin c = 16'(m); end
        end
        return {1'b0, ov, c};
    endfunction

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
    endtask

    // Wait (bounded) for done, counting edges from the accept edge (lat0 already elapsed).
    task automatic wait_result(input string tag, input int lat0, input logic [17:0] exp, input int exp_lat);
        int lat;
        lat = lat0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end while (!done && lat < exp_lat + 20);
        check_val({tag, "_lat"},  32'(lat),  32'(exp_lat));
        check_val({tag, "_C"},    32'(C),    32'(exp[15:0]));
        check_val({tag, "_ovf"},  32'(ovf),  32'(exp[16]));
        check_val({tag, "_dz"},   32'(dz),   32'(exp[17]));
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic finish_op(input string tag, input logic [17:0] exp, input int exp_lat);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({tag, "_busy_acc"}, 32'(busy), 32'd1);
        check_val({tag, "_done_acc"}, 32'(done), 32'd0);
        wait_result(tag, 0, exp, exp_lat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra_done;
        int extra_busy;
        logic [15:0] ra, rb;

        // Reset state
        #3;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_C",    32'(C),    32'd0);
        check_val("rst_ovf",  32'(ovf),  32'd0);
        check_val("rst_dz",   32'(dz),   32'd0);
        #9;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        launch(16'h0300, 16'h0200); finish_op("d3div2",   {2'b00, 16'h0180}, LAT);
        @(posedge clk); #1;
        launch(16'hFD00, 16'h0200); finish_op("negA",     {2'b00, 16'hFE80}, LAT);
        launch(16'hFD00, 16'hFE00); finish_op("b2b_negAB",{2'b00, 16'h0180}, LAT);
        launch(16'h0200, 16'h0300); finish_op("twothirds",{2'b00, TWO_THIRDS}, LAT);
        launch(16'h7F00, 16'h0080); finish_op("ovf_pos",  {2'b01, 16'h7FFF}, LAT);
        launch(16'h8000, 16'h0080); finish_op("ovf_neg",  {2'b01, 16'h8000}, LAT);
        launch(16'hFD00, 16'h0000); finish_op("dz_neg",   {2'b10, 16'h8000}, 1);
        launch(16'h0000, 16'h0000); finish_op("dz_zero",  {2'b10, 16'h7FFF}, 1);
        launch(16'h0100, 16'h0100); finish_op("clr_flags",{2'b00, 16'h0100}, LAT);

        // Start while busy is ignored
        @(posedge clk); #1;
        launch(16'h0500, 16'h0300);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        launch(16'h0100, 16'h0700);
        wait_result("ign_start", 4, ref_div(16'h0500, 16'h0300), LAT);

        // Reset in the middle of a division
        launch(16'h0300, 16'h0200);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        check_val("mid_rst_C",    32'(C),    32'd0);
        check_val("mid_rst_ovf",  32'(ovf),  32'd0);
        check_val("mid_rst_dz",   32'(dz),   32'd0);
        launch(16'h0300, 16'h0000);
        repeat (2) begin @(posedge clk); #1; end
        check_val("rst_start_busy", 32'(busy), 32'd0);
        check_val("rst_start_done", 32'(done), 32'd0);
        start = 1'b0;
        rst   = 1'b1;
        extra_done = 0;
        extra_busy = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check_val("post_rst_done", 32'(extra_done), 32'd0);
        check_val("post_rst_busy", 32'(extra_busy), 32'd0);

        // Randomized operands against the reference model
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 16'h0000;
                1: rb = 16'($urandom_range(1, 255));
                2: rb = 16'h0000 - 16'($urandom_range(1, 255));
                3: ra = 16'h8000;
                4: ra = 16'($urandom_range(0, 1023));
                default: ;
            endcase
            launch(ra, rb);
            finish_op($sformatf("rnd%0d", i), ref_div(ra, rb), (rb == 16'h0000) ? 1 : LAT);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
